// File: rtl/pc_sequencer.sv
// MIPS32 fetch program counter: selects the next byte-address PC from the sequential
// step, branch or jump targets, defers redirects across stalls and halts on misaligned targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        flush,
  output logic        fault,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state;
  logic        pending_valid;
  logic [31:0] pending_target;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        apply;
  logic [31:0] apply_target;

  assign pc_plus4  = pc + STEP;
  assign state_dbg = state;

  // Jump beats branch; a fresh redirect beats the one parked during a stall.
  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? {pc_plus4[31:28], jump_index, 2'b00} : branch_target;
    apply           = redirect | pending_valid;
    apply_target    = redirect ? redirect_target : pending_target;
  end

  // fetch_valid qualifies pc: the fetch stage may only consume pc in cycles
  // where fetch_valid is high; there is no back-pressure other than stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= WAIT;
      pc             <= RESET_PC;
      fetch_valid    <= 1'b0;
      flush          <= 1'b0;
      fault          <= 1'b0;
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else begin
      flush <= 1'b0;
      case (state)
        WAIT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (stall) begin
            if (redirect) begin
              pending_valid  <= 1'b1;
              pending_target <= redirect_target;
            end
          end else begin
            pending_valid <= 1'b0;
            if (apply) begin
              // A misaligned target is never loaded; fetch stops until reset.
              if (apply_target[1:0] != 2'b00) begin
                state       <= HALT;
                fetch_valid <= 1'b0;
                fault       <= 1'b1;
              end else begin
                pc    <= apply_target;
                flush <= 1'b1;
              end
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HALT: begin
          fetch_valid <= 1'b0;
          fault       <= 1'b1;
        end
        default: begin
          state       <= HALT;
          fetch_valid <= 1'b0;
          fault       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run against a
// cycle-level reference model of the fetch PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        fault;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_flush;
  logic        m_fault;
  int          m_phase;          // 0 waiting, 1 running, 2 halted
  logic [31:0] m_pend[$];        // at most one parked redirect

  pc_sequencer #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .flush(flush), .fault(fault), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc = RESET_PC; m_valid = 1'b0; m_flush = 1'b0; m_fault = 1'b0;
    m_phase = 0; m_pend.delete();
  endfunction

  function automatic void model_apply(input logic [31:0] t);
    if (t % 4 != 0) begin
      m_phase = 2; m_valid = 1'b0; m_fault = 1'b1;
    end else begin
      m_pc = t; m_flush = 1'b1;
    end
  endfunction

  function automatic void model_edge(input logic st, input logic br, input logic [31:0] bt,
                                     input logic j, input logic [25:0] idx);
    logic [31:0] tgt;
    logic        red;
    red = br | j;
    tgt = j ? (((m_pc + 32'd4) & 32'hF000_0000) | (32'(idx) * 32'd4)) : bt;
    m_flush = 1'b0;
    if (m_phase == 0) begin
      m_phase = 1; m_valid = 1'b1;
    end else if (m_phase == 1) begin
      if (st) begin
        if (red) begin m_pend.delete(); m_pend.push_back(tgt); end
      end else begin
        if (red) model_apply(tgt);
        else if (m_pend.size() != 0) model_apply(m_pend[0]);
        else m_pc = m_pc + 32'd4;
        m_pend.delete();
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Drives inputs for one cycle from the falling edge; returns at the next falling edge.
  task automatic tick(input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic [25:0] idx);
    stall = st; branch_taken = br; branch_target = bt; jump = j; jump_index = idx;
    @(posedge clk);
    if (rst_n) model_edge(st, br, bt, j, idx);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
  endtask

  task automatic reset_assert();
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic reset_release();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_assert();
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, RESET_PC); end
    checks++; if ({fetch_valid, flush, fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {fetch_valid, flush, fault}); end
    reset_release();
    // WAIT cycle: redirect and stall must be ignored
    checks++; if (fetch_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL wait_cycle got pc %h valid %b exp pc 0 valid 0", pc, fetch_valid); end
    tick(1'b1, 1'b1, 32'h0000_0800, 1'b0, 26'h0);
    checks++; if (pc !== 32'h0 || fetch_valid !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL first_run got pc %h valid %b flush %b exp 0 1 0", pc, fetch_valid, flush); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      checks++; if (pc !== 32'(i * 4) || pc !== m_pc) begin errors++; $display("FAIL seq_pc got %h exp %h", pc, 32'(i * 4)); end
      checks++; if (pc_plus4 !== 32'(i * 4 + 4)) begin errors++; $display("FAIL seq_plus4 got %h exp %h", pc_plus4, 32'(i * 4 + 4)); end
    end
    idle(1);
  endtask

  task automatic test_branch();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL branch_start got %h exp 00000010", pc); end
    tick(1'b0, 1'b1, 32'h40, 1'b0, 26'h0);
    checks++; if (pc !== 32'h40 || flush !== 1'b1) begin errors++; $display("FAIL branch_apply got pc %h flush %b exp 40 1", pc, flush); end
    idle(1);
    checks++; if (pc !== 32'h44 || flush !== 1'b0) begin errors++; $display("FAIL branch_after got pc %h flush %b exp 44 0", pc, flush); end
  endtask

  task automatic test_stall_pending();
    tick(1'b0, 1'b1, 32'h20, 1'b0, 26'h0);
    tick(1'b1, 1'b1, 32'h80, 1'b0, 26'h0);
    tick(1'b1, 1'b1, 32'h90, 1'b0, 26'h0);
    tick(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
    checks++; if (pc !== 32'h20 || flush !== 1'b0) begin errors++; $display("FAIL stall_hold got pc %h flush %b exp 20 0", pc, flush); end
    idle(1);
    checks++; if (pc !== 32'h90 || flush !== 1'b1) begin errors++; $display("FAIL stall_release got pc %h flush %b exp 90 1", pc, flush); end
    idle(1);
    checks++; if (pc !== 32'h94 || flush !== 1'b0) begin errors++; $display("FAIL stall_after got pc %h flush %b exp 94 0", pc, flush); end
  endtask

  task automatic test_jump_priority();
    tick(1'b0, 1'b1, 32'h1000_0000, 1'b0, 26'h0);
    tick(1'b0, 1'b1, 32'h0000_0044, 1'b1, 26'h0000100);
    checks++; if (pc !== 32'h1000_0400 || flush !== 1'b1) begin errors++; $display("FAIL jump_wins got pc %h flush %b exp 10000400 1", pc, flush); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp 00000000", pc_plus4); end
    idle(1);
    checks++; if (pc !== 32'h0 || fault !== 1'b0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc got pc %h fault %b valid %b exp 0 0 1", pc, fault, fetch_valid); end
  endtask

  task automatic test_misaligned();
    tick(1'b0, 1'b1, 32'h40, 1'b0, 26'h0);
    tick(1'b0, 1'b1, 32'h42, 1'b0, 26'h0);
    checks++; if (pc !== 32'h40 || fault !== 1'b1 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL misalign got pc %h fault %b valid %b flush %b exp 40 1 0 0", pc, fault, fetch_valid, flush); end
    tick(1'b0, 1'b1, 32'h100, 1'b0, 26'h0);
    idle(3);
    checks++; if (pc !== 32'h40 || fault !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_frozen got pc %h fault %b valid %b exp 40 1 0", pc, fault, fetch_valid); end
    reset_assert();
    checks++; if (pc !== RESET_PC || fault !== 1'b0) begin errors++; $display("FAIL halt_reset got pc %h fault %b exp %h 0", pc, fault, RESET_PC); end
    reset_release();
    idle(2);
  endtask

  task automatic test_pending_misaligned();
    tick(1'b1, 1'b1, 32'h0000_0203, 1'b0, 26'h0);
    checks++; if (fault !== 1'b0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL parked_misalign got fault %b valid %b exp 0 1", fault, fetch_valid); end
    idle(1);
    checks++; if (fault !== 1'b1 || pc !== 32'h4) begin errors++; $display("FAIL applied_misalign got fault %b pc %h exp 1 4", fault, pc); end
    reset_assert();
    reset_release();
    idle(2);
  endtask

  task automatic test_reset_mid_stall();
    tick(1'b1, 1'b1, 32'h80, 1'b0, 26'h0);
    #2;
    reset_assert();
    checks++; if (pc !== RESET_PC || fetch_valid !== 1'b0) begin errors++; $display("FAIL async_reset got pc %h valid %b exp %h 0", pc, fetch_valid, RESET_PC); end
    reset_release();
    idle(3);
    checks++; if (pc !== 32'h8 || flush !== 1'b0) begin errors++; $display("FAIL pending_discard got pc %h flush %b exp 8 0", pc, flush); end
  endtask

  task automatic test_random();
    logic        st, br, j;
    logic [31:0] bt;
    logic [25:0] idx;
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 9) == 0);
      bt  = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 24) == 0) bt[1:0] = 2'($urandom_range(1, 3));
      idx = 26'($urandom());
      tick(st, br, bt, j, idx);
      checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || fetch_valid !== m_valid || flush !== m_flush || fault !== m_fault) begin
        errors++;
        $display("FAIL random[%0d] got pc %h p4 %h v%b f%b x%b exp pc %h p4 %h v%b f%b x%b", i,
                 pc, pc_plus4, fetch_valid, flush, fault, m_pc, m_pc + 32'd4, m_valid, m_flush, m_fault);
      end
      if (m_phase == 2 && $urandom_range(0, 3) == 0) begin
        reset_assert();
        reset_release();
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_index = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_branch();
    test_stall_pending();
    test_jump_priority();
    test_wrap();
    test_misaligned();
    test_pending_misaligned();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
